// File: rtl/f2c_burst_feeder_if.sv
// F2C FIFO read-port bundle. The master side is the burst feeder that issues
// reads; the slave side is the FIFO that answers them.
interface f2c_burst_feeder_if #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 11
) ();
  logic              fifo_rd_en;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_rd_count;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_dout_valid;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_rd_count,
    input  fifo_dout,
    input  fifo_dout_valid
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_rd_count,
    output fifo_dout,
    output fifo_dout_valid
  );
endinterface

// File: rtl/f2c_burst_feeder.sv
// Drains the F2C FIFO toward the chip bus in unbroken bursts and keeps burst statistics.
// Define F2C_SHORT_BURST_EN to allow short-window starts below HI_WM.
module f2c_burst_feeder #(
  parameter int DATA_W = 128,
  parameter int CNT_W  = 11,
  parameter int HI_WM  = 200,
  parameter int SB_MIN = 9,
  parameter int SB_MAX = 19
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                sel_chip,
  input  logic                c2f_busy,
  f2c_burst_feeder_if.master  fifo,
  output logic                data_vld,
  output logic [DATA_W-1:0]   data_to_chip,
  output logic                busy,
  output logic [15:0]         burst_cnt,
  output logic [15:0]         last_burst_len
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HI_WM_C  = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0] SB_MIN_C = CNT_W'(SB_MIN);
  localparam logic [CNT_W-1:0] SB_MAX_C = CNT_W'(SB_MAX);
  localparam logic [1:0]       DRAIN_LAST = 2'd2;

  state_t            state_q, state_d;
  logic [1:0]        drain_cnt_q, drain_cnt_d;
  logic              empty_q, empty_d;
  logic              rd_en_q, rd_en_d;
  logic              v1_q, v1_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] d1_q, d1_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic [15:0]       burst_cnt_q, burst_cnt_d;
  logic [15:0]       last_len_q, last_len_d;

  logic long_start;
  logic short_ok;
  logic short_start;
  logic start;
  logic drain_done;

  assign long_start = sel_chip && (fifo.fifo_rd_count >= HI_WM_C);
  assign short_ok   = sel_chip && !c2f_busy && !fifo.fifo_empty &&
                      (fifo.fifo_rd_count >= SB_MIN_C) &&
                      (fifo.fifo_rd_count <= SB_MAX_C);

`ifdef F2C_SHORT_BURST_EN
  assign short_start = short_ok;
`else
  logic unused_short_ok;
  assign unused_short_ok = short_ok;
  assign short_start     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    word_cnt_d  = word_cnt_q;
    burst_cnt_d = burst_cnt_q;
    last_len_d  = last_len_q;
    start       = 1'b0;
    drain_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (long_start || short_start) begin
          state_d = STREAM;
          start   = 1'b1;
        end
      end
      STREAM: begin
        if (fifo.fifo_empty || !sel_chip) begin
          state_d     = DRAIN;
          drain_cnt_d = 2'd0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = IDLE;
          drain_cnt_d = 2'd0;
          drain_done  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        drain_cnt_d = 2'd0;
      end
    endcase

    if (start) begin
      word_cnt_d = 16'd0;
    end else if (fifo.fifo_dout_valid && (word_cnt_q != 16'hFFFF)) begin
      word_cnt_d = word_cnt_q + 16'd1;
    end

    // word_cnt_d so a word landing in the final DRAIN cycle is still counted
    if (drain_done) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
      last_len_d  = word_cnt_d;
    end

    // Reads begin the cycle after STREAM is entered and stop as soon as an exit is seen
    rd_en_d = (state_q == STREAM) && (state_d == STREAM) && !empty_q;
    empty_d = fifo.fifo_empty;

    v1_d   = fifo.fifo_dout_valid;
    vld_d  = v1_q | fifo.fifo_dout_valid;
    d1_d   = fifo.fifo_dout_valid ? fifo.fifo_dout : d1_q;
    dout_d = v1_q ? d1_q : dout_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      drain_cnt_q <= 2'd0;
      empty_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      v1_q        <= 1'b0;
      vld_q       <= 1'b0;
      d1_q        <= '0;
      dout_q      <= '0;
      word_cnt_q  <= 16'd0;
      burst_cnt_q <= 16'd0;
      last_len_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      empty_q     <= empty_d;
      rd_en_q     <= rd_en_d;
      v1_q        <= v1_d;
      vld_q       <= vld_d;
      d1_q        <= d1_d;
      dout_q      <= dout_d;
      word_cnt_q  <= word_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      last_len_q  <= last_len_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en_q;
  assign data_vld        = vld_q;
  assign data_to_chip    = dout_q;
  assign busy            = (state_q != IDLE);
  assign burst_cnt       = burst_cnt_q;
  assign last_burst_len  = last_len_q;

endmodule

// File: tb/tb_f2c_burst_feeder.sv
// Scoreboard bench for f2c_burst_feeder: a behavioural FIFO answers reads, stimulus
// queues expected chip words and run lengths, and a monitor checks them as they appear.
module tb_f2c_burst_feeder;
  localparam int DW = 128;
  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sel_chip;
  logic          c2f_busy;
  logic          data_vld;
  logic [DW-1:0] data_to_chip;
  logic          busy;
  logic [15:0]   burst_cnt;
  logic [15:0]   last_burst_len;

  f2c_burst_feeder_if #(.DATA_W(DW), .CNT_W(CW)) fifo_if ();

  f2c_burst_feeder #(
    .DATA_W(DW), .CNT_W(CW), .HI_WM(200), .SB_MIN(9), .SB_MAX(19)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sel_chip       (sel_chip),
    .c2f_busy       (c2f_busy),
    .fifo           (fifo_if),
    .data_vld       (data_vld),
    .data_to_chip   (data_to_chip),
    .busy           (busy),
    .burst_cnt      (burst_cnt),
    .last_burst_len (last_burst_len)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  int            exp_bursts = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_data[$];
  int            exp_run[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int tag, input int idx);
    return {32'(tag), 32'(idx), ~32'(idx), 32'hC0DE_0000 ^ 32'(idx)};
  endfunction

  task automatic fifo_refresh();
    fifo_if.fifo_rd_count = 11'(fq.size());
    fifo_if.fifo_empty    = (fq.size() == 0);
  endtask

  task automatic clear_fifo();
    fq.delete();
    fifo_refresh();
  endtask

  // Push n words; the first n_exp are expected to reach the chip
  task automatic load(input int tag, input int n, input int n_exp);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = mk_word(tag, i);
      fq.push_back(w);
      if (i < n_exp) exp_data.push_back(w);
    end
    fifo_refresh();
  endtask

  // Behavioural FIFO: a read accepted at an edge returns its word one cycle later
  bit acc;
  always begin
    @(posedge clk);
    acc = fifo_if.fifo_rd_en && (fq.size() > 0);
    #1;
    if (acc) begin
      fifo_if.fifo_dout       = fq.pop_front();
      fifo_if.fifo_dout_valid = 1'b1;
    end else begin
      fifo_if.fifo_dout_valid = 1'b0;
    end
    fifo_refresh();
  end

  // Monitor: first data_vld cycle is the lead cycle; words follow on every later one
  int run_len = 0;
  bit vld_prev = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      exp_data.delete();
      run_len  = 0;
      vld_prev = 1'b0;
    end else begin
      if (data_vld) run_len++;
      if (data_vld && vld_prev) begin
        if (exp_data.size() == 0) chk("data_extra", 128'(1), 128'(0));
        else chk("data_word", data_to_chip, exp_data.pop_front());
      end
      if (!data_vld && vld_prev) begin
        if (exp_run.size() == 0) chk("vld_run_unexpected", 128'(run_len), 128'(0));
        else chk("vld_run", 128'(run_len), 128'(exp_run.pop_front()));
        run_len = 0;
      end
      vld_prev = data_vld;
    end
  end

  task automatic wait_busy(input logic val, input int budget, input string name);
    int n = 0;
    while (busy !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 128'(busy), 128'(val));
  endtask

  task automatic run_burst(input string name, input int len);
    exp_run.push_back(len + 1);
    wait_busy(1'b1, 50, {name, "_start"});
    wait_busy(1'b0, len + 100, {name, "_end"});
    exp_bursts++;
    chk({name, "_burst_cnt"}, 128'(burst_cnt), 128'(exp_bursts));
    chk({name, "_len"}, 128'(last_burst_len), 128'(len));
    $display("burst %s: len=%0d burst_cnt=%0d", name, last_burst_len, burst_cnt);
  endtask

  task automatic no_start(input int cycles, input string name);
    bit seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (fifo_if.fifo_rd_en || busy) seen = 1'b1;
    end
    chk(name, 128'(seen), 128'(0));
    $display("idle %s: %0d cycles, started=%0d", name, cycles, seen);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    sel_chip = 1'b0;
    c2f_busy = 1'b0;
    fifo_if.fifo_dout = '0;
    fifo_if.fifo_dout_valid = 1'b0;
    fifo_refresh();
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 128'(fifo_if.fifo_rd_en), 128'(0));
    chk("rst_data_vld", 128'(data_vld), 128'(0));
    chk("rst_data", data_to_chip, 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_burst_cnt", 128'(burst_cnt), 128'(0));
    chk("rst_last_len", 128'(last_burst_len), 128'(0));
    rstn = 1'b1;
    sel_chip = 1'b1;

    load(1, 250, 250);
    run_burst("long250", 250);
    chk("long_fifo_left", 128'(fq.size()), 128'(0));

`ifdef F2C_SHORT_BURST_EN
    load(2, 12, 12);
    run_burst("short12", 12);
    c2f_busy = 1'b1;
    load(3, 12, 12);
    no_start(100, "short12_c2f_busy");
    c2f_busy = 1'b0;
    run_burst("short12_after_c2f", 12);
`else
    load(2, 12, 0);
    no_start(500, "short12_disabled");
    clear_fifo();
`endif

    load(4, 8, 0);    no_start(40, "cnt8");   clear_fifo();
    load(5, 20, 0);   no_start(40, "cnt20");  clear_fifo();
    load(6, 199, 0);  no_start(40, "cnt199"); clear_fifo();
`ifdef F2C_SHORT_BURST_EN
    load(7, 9, 9);    run_burst("cnt9", 9);
    load(8, 19, 19);  run_burst("cnt19", 19);
`else
    load(7, 9, 0);    no_start(40, "cnt9_disabled");  clear_fifo();
    load(8, 19, 0);   no_start(40, "cnt19_disabled"); clear_fifo();
`endif
    load(9, 200, 200);
    run_burst("cnt200", 200);

    // Abort: rd_en first high in cycle t, sel_chip dropped in t+49 -> 50 words read
    load(10, 300, 50);
    exp_run.push_back(51);
    n = 0;
    while (!fifo_if.fifo_rd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("abort_rd_start", 128'(fifo_if.fifo_rd_en), 128'(1));
    repeat (49) @(negedge clk);
    sel_chip = 1'b0;
    @(negedge clk);
    chk("abort_rd_en_low", 128'(fifo_if.fifo_rd_en), 128'(0));
    chk("abort_drain1", 128'(busy), 128'(1));
    @(negedge clk);
    chk("abort_drain2", 128'(busy), 128'(1));
    @(negedge clk);
    chk("abort_drain3", 128'(busy), 128'(1));
    @(negedge clk);
    chk("abort_idle", 128'(busy), 128'(0));
    exp_bursts++;
    chk("abort_burst_cnt", 128'(burst_cnt), 128'(exp_bursts));
    chk("abort_len", 128'(last_burst_len), 128'(50));
    chk("abort_fifo_left", 128'(fq.size()), 128'(250));
    $display("burst abort: len=%0d burst_cnt=%0d left=%0d", last_burst_len, burst_cnt, fq.size());
    clear_fifo();

    // Asynchronous reset in the middle of a burst
    sel_chip = 1'b1;
    load(11, 250, 250);
    wait_busy(1'b1, 50, "rst_burst_start");
    repeat (20) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_rd_en", 128'(fifo_if.fifo_rd_en), 128'(0));
    chk("arst_data_vld", 128'(data_vld), 128'(0));
    chk("arst_data", data_to_chip, 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_burst_cnt", 128'(burst_cnt), 128'(0));
    chk("arst_last_len", 128'(last_burst_len), 128'(0));
    sel_chip = 1'b0;
    clear_fifo();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", 128'(busy), 128'(0));
    chk("post_rst_burst_cnt", 128'(burst_cnt), 128'(0));
    chk("post_rst_rd_en", 128'(fifo_if.fifo_rd_en), 128'(0));
    $display("reset: busy=%0d burst_cnt=%0d", busy, burst_cnt);

    chk("exp_data_left", 128'(exp_data.size()), 128'(0));
    chk("exp_run_left", 128'(exp_run.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
